// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: bus layouts, widths and entry state.
package if_stage_pkg;

    localparam int PF_BUS_W = 71;
    localparam int FS_BUS_W = 103;

    typedef enum logic [1:0] {
        FS_EMPTY = 2'd0,
        FS_WAIT  = 2'd1,
        FS_READY = 2'd2
    } fs_state_e;

    typedef struct packed {
        logic        tlb_refill;
        logic [31:0] badvaddr;
        logic        has_ex;
        logic [4:0]  ex_type;
        logic [31:0] pc;
    } pf_bus_t;

    typedef struct packed {
        logic        tlb_refill;
        logic [31:0] badvaddr;
        logic        has_ex;
        logic [4:0]  ex_type;
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_bus_t;

    function automatic fs_bus_t make_fs_bus(input pf_bus_t pf, input logic [31:0] inst);
        fs_bus_t b;
        b.tlb_refill = pf.tlb_refill;
        b.badvaddr   = pf.badvaddr;
        b.has_ex     = pf.has_ex;
        b.ex_type    = pf.ex_type;
        b.inst       = inst;
        b.pc         = pf.pc;
        return b;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Signals between pre-IF / instruction cache / ID and the IF stage.
interface if_stage_if;
    import if_stage_pkg::*;

    logic                to_fs_valid;
    logic [PF_BUS_W-1:0] preif_to_fs_bus;
    logic                fs_allowin;
    logic                fs_has_inst;
    logic                inst_cache_data_ok;
    logic [31:0]         inst_cache_rdata;
    logic                ds_allowin;
    logic                fs_to_ds_valid;
    logic [FS_BUS_W-1:0] fs_to_ds_bus;
    logic                fs_cancel;

    modport slave (
        input  to_fs_valid, preif_to_fs_bus, inst_cache_data_ok, inst_cache_rdata,
               ds_allowin, fs_cancel,
        output fs_allowin, fs_has_inst, fs_to_ds_valid, fs_to_ds_bus
    );

    modport master (
        output to_fs_valid, preif_to_fs_bus, inst_cache_data_ok, inst_cache_rdata,
               ds_allowin, fs_cancel,
        input  fs_allowin, fs_has_inst, fs_to_ds_valid, fs_to_ds_bus
    );

endinterface

// File: rtl/if_stage.sv
// MIPS IF stage: one in-flight fetch, instruction buffer for ID stalls, and a
// drop counter that discards cache returns belonging to flushed fetches.
module if_stage
    import if_stage_pkg::*;
(
    input logic       clk,
    input logic       reset,
    if_stage_if.slave bus
);

    fs_state_e   state_q, state_d;
    logic [1:0]  drop_cnt_q, drop_cnt_d;
    pf_bus_t     pf_q, pf_d;
    logic [31:0] inst_buf_q, inst_buf_d;

    logic        st_empty, st_wait, st_ready;
    logic        drop_zero, data_mine, ready_go;
    logic        allowin, accept, to_ds_valid;
    logic        drop_inc, drop_dec;
    logic [31:0] inst;

    assign st_empty  = (state_q == FS_EMPTY);
    assign st_wait   = (state_q == FS_WAIT);
    assign st_ready  = (state_q == FS_READY);
    assign drop_zero = (drop_cnt_q == 2'd0);

    // A return only belongs to the current entry once all stale returns are gone.
    assign data_mine   = st_wait & bus.inst_cache_data_ok & drop_zero;
    assign ready_go    = st_ready | data_mine;
    assign allowin     = ~reset & (st_empty | (ready_go & bus.ds_allowin) | bus.fs_cancel);
    assign accept      = bus.to_fs_valid & allowin;
    assign to_ds_valid = ~reset & ready_go & ~bus.fs_cancel;

    // Killing a fetch whose data is still outstanding leaves one stale return to skip.
    assign drop_inc = bus.fs_cancel & st_wait & ~data_mine;
    assign drop_dec = bus.inst_cache_data_ok & ~drop_zero;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        pf_d       = pf_q;
        inst_buf_d = inst_buf_q;

        if (drop_inc && !drop_dec) begin
            drop_cnt_d = (drop_cnt_q == 2'd3) ? 2'd3 : drop_cnt_q + 2'd1;
        end else if (drop_dec && !drop_inc) begin
            drop_cnt_d = drop_cnt_q - 2'd1;
        end

        if (bus.fs_cancel || st_empty || (to_ds_valid && bus.ds_allowin)) begin
            state_d = accept ? FS_WAIT : FS_EMPTY;
        end else if (data_mine) begin
            // ID is stalled: park the returned word until it is taken.
            state_d    = FS_READY;
            inst_buf_d = bus.inst_cache_rdata;
        end

        if (accept) begin
            pf_d = pf_bus_t'(bus.preif_to_fs_bus);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: payload and inst_buf are cleared too, so the ID bus reads 0 out of reset.
            state_q    <= FS_EMPTY;
            drop_cnt_q <= 2'd0;
            pf_q       <= '0;
            inst_buf_q <= '0;
        end else begin
            // NOTE: non-blocking updates so all state flops sample the same cycle's values.
            state_q    <= state_d;
            drop_cnt_q <= drop_cnt_d;
            pf_q       <= pf_d;
            inst_buf_q <= inst_buf_d;
        end
    end

    // Exception entries carry no instruction word.
    assign inst = pf_q.has_ex ? 32'd0 :
                  st_ready    ? inst_buf_q :
                  st_wait     ? bus.inst_cache_rdata : 32'd0;

    assign bus.fs_allowin     = allowin;
    assign bus.fs_has_inst    = ~reset & (st_wait | st_ready) & ~bus.fs_cancel;
    assign bus.fs_to_ds_valid = to_ds_valid;
    assign bus.fs_to_ds_bus   = reset ? '0 : make_fs_bus(pf_q, inst);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed vector table for the corner cases, then random
// traffic against a queue-based model of outstanding cache requests.
module tb_if_stage;
    import if_stage_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    if_stage_if ifc();

    if_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic drive(input logic v, input pf_bus_t pf, input logic dok,
                         input logic [31:0] rd, input logic dsa, input logic cn);
        @(negedge clk);
        ifc.to_fs_valid        = v;
        ifc.preif_to_fs_bus    = pf;
        ifc.inst_cache_data_ok = dok;
        ifc.inst_cache_rdata   = rd;
        ifc.ds_allowin         = dsa;
        ifc.fs_cancel          = cn;
        #1;
    endtask

    typedef struct {
        logic        v;
        pf_bus_t     pf;
        logic        dok;
        logic [31:0] rd;
        logic        dsa;
        logic        cn;
        logic        e_valid;
        logic        e_allow;
        logic        e_has;
        fs_bus_t     e_bus;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [31:0] pc, input logic dok,
                                input logic [31:0] rd, input logic dsa, input logic cn,
                                input logic ev, input logic ea, input logic eh,
                                input logic [31:0] epc, input logic [31:0] einst);
        vec_t t;
        t.v = v; t.pf = '0; t.pf.pc = pc;
        t.dok = dok; t.rd = rd; t.dsa = dsa; t.cn = cn;
        t.e_valid = ev; t.e_allow = ea; t.e_has = eh;
        t.e_bus = '0; t.e_bus.pc = epc; t.e_bus.inst = einst;
        return t;
    endfunction

    vec_t tbl[$];

    // Reference model: the live entry plus a FIFO of outstanding requests,
    // each marked alive (belongs to the live entry) or dead (cancelled).
    logic        ent_v, ent_hd;
    logic [31:0] ent_data;
    pf_bus_t     ent_pf;
    bit          pend[$];

    initial begin
        vec_t    t;
        pf_bus_t pf;
        fs_bus_t eb;
        logic    v, dok, dsa, cn, arrive, have, e_valid, e_allow, e_has;
        logic [31:0] rd, data_now;
        int      dead, delivered;

        reset = 1'b1;
        drive(1'b0, '0, 1'b0, 32'h0, 1'b0, 1'b0);
        check("rst_allowin", ifc.fs_allowin, 1'b0);
        check("rst_valid",   ifc.fs_to_ds_valid, 1'b0);
        check("rst_has",     ifc.fs_has_inst, 1'b0);
        check("rst_bus",     ifc.fs_to_ds_bus, '0);
        @(posedge clk); #1 reset = 1'b0;

        //           v  pc            dok rd            dsa cn  ev ea eh  epc           einst
        tbl.push_back(mk(1, 32'hbfc00000, 0, 32'h0,        1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(1, 32'hbfc00004, 1, 32'h24080001, 1, 0,  1, 1, 1, 32'hbfc00000, 32'h24080001));
        tbl.push_back(mk(1, 32'hbfc00008, 1, 32'h11111111, 1, 0,  1, 1, 1, 32'hbfc00004, 32'h11111111));
        tbl.push_back(mk(0, 32'h0,        1, 32'h22222222, 1, 0,  1, 1, 1, 32'hbfc00008, 32'h22222222));
        // ID stall: word parked in inst_buf while rdata turns to junk
        tbl.push_back(mk(1, 32'h80000010, 0, 32'h0,        0, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h12345678, 0, 0,  1, 0, 1, 32'h80000010, 32'h12345678));
        tbl.push_back(mk(0, 32'h0,        0, 32'hdeadbeef, 0, 0,  1, 0, 1, 32'h80000010, 32'h12345678));
        tbl.push_back(mk(0, 32'h0,        0, 32'hdeadbeef, 0, 0,  1, 0, 1, 32'h80000010, 32'h12345678));
        tbl.push_back(mk(0, 32'h0,        0, 32'hdeadbeef, 1, 0,  1, 1, 1, 32'h80000010, 32'h12345678));
        tbl.push_back(mk(0, 32'h0,        0, 32'hdeadbeef, 1, 0,  0, 1, 0, 32'h0,        32'h0));
        // cancel before data with reflush accept
        tbl.push_back(mk(1, 32'h80000100, 0, 32'h0,        1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(1, 32'hbfc00380, 0, 32'h0,        1, 1,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'haaaaaaaa, 1, 0,  0, 0, 1, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'hbbbbbbbb, 1, 0,  1, 1, 1, 32'hbfc00380, 32'hbbbbbbbb));
        // two cancels while waiting
        tbl.push_back(mk(1, 32'h80000200, 0, 32'h0,        1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(1, 32'h80000204, 0, 32'h0,        1, 1,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(1, 32'h80000208, 0, 32'h0,        1, 1,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h00000001, 1, 0,  0, 0, 1, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h00000002, 1, 0,  0, 0, 1, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h33333333, 1, 0,  1, 1, 1, 32'h80000208, 32'h33333333));
        // exception entry: inst forced to 0
        t = mk(1, 32'h80000300, 0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 32'h0);
        t.pf.has_ex = 1'b1; t.pf.ex_type = 5'h4; t.pf.badvaddr = 32'h80000002;
        tbl.push_back(t);
        t = mk(0, 32'h0, 1, 32'h44444444, 1, 0, 1, 1, 1, 32'h80000300, 32'h0);
        t.e_bus.has_ex = 1'b1; t.e_bus.ex_type = 5'h4; t.e_bus.badvaddr = 32'h80000002;
        tbl.push_back(t);
        // cancel together with data_ok: consumed, nothing left to drop
        tbl.push_back(mk(1, 32'h80000400, 0, 32'h0,        1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h55555555, 1, 1,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h0,        1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(1, 32'h80000500, 0, 32'h0,        1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h66666666, 1, 0,  1, 1, 1, 32'h80000500, 32'h66666666));
        // accept in the same cycle as a stale return being dropped
        tbl.push_back(mk(1, 32'h80000600, 0, 32'h0,        1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(1, 32'h80000604, 0, 32'h0,        1, 1,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        0, 32'h0,        1, 1,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(1, 32'h80000608, 1, 32'h00000007, 1, 0,  0, 1, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h00000008, 1, 0,  0, 0, 1, 32'h0,        32'h0));
        tbl.push_back(mk(0, 32'h0,        1, 32'h77777777, 1, 0,  1, 1, 1, 32'h80000608, 32'h77777777));

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].v, tbl[i].pf, tbl[i].dok, tbl[i].rd, tbl[i].dsa, tbl[i].cn);
            check($sformatf("vec%0d_valid", i),  ifc.fs_to_ds_valid, tbl[i].e_valid);
            check($sformatf("vec%0d_allowin", i), ifc.fs_allowin,    tbl[i].e_allow);
            check($sformatf("vec%0d_has", i),     ifc.fs_has_inst,   tbl[i].e_has);
            if (tbl[i].e_valid)
                check($sformatf("vec%0d_bus", i), ifc.fs_to_ds_bus, tbl[i].e_bus);
        end

        // Random phase from a fresh reset.
        @(negedge clk);
        reset = 1'b1;
        ifc.to_fs_valid = 1'b0; ifc.inst_cache_data_ok = 1'b0; ifc.fs_cancel = 1'b0;
        @(posedge clk); #1 reset = 1'b0;
        ent_v = 1'b0; ent_hd = 1'b0; ent_data = '0; ent_pf = '0;
        pend.delete();
        delivered = 0;

        for (int c = 0; c < 3000; c++) begin
            dead = 0;
            foreach (pend[k]) if (!pend[k]) dead++;
            dsa = ($urandom % 4) != 0;
            cn  = (($urandom % 8) == 0) && (dead < 3);
            dok = (pend.size() > 0) && (($urandom % 2) == 1);
            rd  = $urandom;
            pf.pc = $urandom; pf.badvaddr = $urandom;
            pf.has_ex = ($urandom % 8) == 0;
            pf.ex_type = 5'($urandom);
            pf.tlb_refill = 1'($urandom);

            arrive   = dok && pend[0];
            have     = ent_v && (ent_hd || arrive);
            data_now = ent_hd ? ent_data : rd;
            e_valid  = have && !cn;
            e_allow  = !ent_v || (have && dsa) || cn;
            e_has    = ent_v && !cn;
            v        = e_allow && (($urandom % 4) != 0);

            drive(v, pf, dok, rd, dsa, cn);
            check("rnd_valid",   ifc.fs_to_ds_valid, e_valid);
            check("rnd_allowin", ifc.fs_allowin,     e_allow);
            check("rnd_has",     ifc.fs_has_inst,    e_has);
            if (e_valid) begin
                eb.tlb_refill = ent_pf.tlb_refill;
                eb.badvaddr   = ent_pf.badvaddr;
                eb.has_ex     = ent_pf.has_ex;
                eb.ex_type    = ent_pf.ex_type;
                eb.inst       = ent_pf.has_ex ? 32'h0 : data_now;
                eb.pc         = ent_pf.pc;
                check("rnd_bus", ifc.fs_to_ds_bus, eb);
                if (dsa) delivered++;
            end

            if (dok) void'(pend.pop_front());
            if (cn) begin
                ent_v = 1'b0;
                foreach (pend[k]) pend[k] = 1'b0;
            end else if (e_valid && dsa) begin
                ent_v = 1'b0;
            end else if (arrive) begin
                ent_hd = 1'b1; ent_data = rd;
            end
            if (v) begin
                ent_v = 1'b1; ent_hd = 1'b0; ent_pf = pf;
                pend.push_back(1'b1);
            end
        end
        check("rnd_progress", delivered > 200, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
